// File: rtl/pusch_dr_pkg.sv
// pusch_dr_pkg: shared slot type, list depth and FSM states for the beam power ranker
package pusch_dr_pkg;
    localparam int TOPK = 16;
    localparam int PWR_W = 32;
    localparam int IDX_W = 8;
    localparam logic [IDX_W-1:0] EMPTY_IDX = '1;
    typedef struct packed {
        logic [PWR_W-1:0] pwr;
        logic [IDX_W-1:0] idx;
        logic vld;
    } beam_slot_t;
    localparam beam_slot_t EMPTY_SLOT = '0;
    typedef enum logic {IDLE, ACC} rank_state_t;
endpackage

// File: rtl/beam_rank_cell.sv
// beam_rank_cell: one slot of the insertion list; keeps, takes the new sample, or shifts from above
module beam_rank_cell
    import pusch_dr_pkg::*;
(
    input  beam_slot_t own,
    input  beam_slot_t upper,
    input  beam_slot_t smp,
    input  logic       upper_ge,
    output beam_slot_t nxt,
    output logic       ge
);
    // >= keeps an earlier equal-power sample above the new one
    always_comb begin
        ge = own.vld && (own.pwr >= smp.pwr);
        nxt = ge ? own : upper_ge ? smp : upper;
    end
endmodule

// File: rtl/beam_pwr_rank.sv
// beam_pwr_rank: streaming top-16 beam power ranker publishing one sorted snapshot per RBG
module beam_pwr_rank
    import pusch_dr_pkg::*;
#(
    parameter int PWR_WIDTH = PWR_W,
    parameter int IDX_WIDTH = IDX_W,
    parameter int CNT_WIDTH = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_pwr_vld,
    input  logic                                i_pwr_sop,
    input  logic                                i_pwr_eop,
    input  logic [PWR_WIDTH-1:0]                i_pwr,
    input  logic [IDX_WIDTH-1:0]                i_pwr_idx,
    input  logic                                i_rbg_load,
    output logic [TOPK-1:0][PWR_WIDTH-1:0]      o_sort_pwr,
    output logic [TOPK-1:0][IDX_WIDTH-1:0]      o_sort_idx,
    output logic [4:0]                          o_sort_cnt,
    output logic                                o_sort_sop,
    output logic                                o_rbg_load,
    output logic                                o_err_sop
);
    rank_state_t state, state_nxt;
    logic vld, sop, eop, load, accept, snap, snap_load;
    logic [PWR_W-1:0] pwr;
    logic [IDX_W-1:0] idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [TOPK-1:0] ge, up_ge;
    beam_slot_t list [TOPK];
    beam_slot_t view [TOPK];
    beam_slot_t up [TOPK];
    beam_slot_t nxt [TOPK];
    beam_slot_t smp;

    // an sop beat sees an empty list so it clears and inserts in one update
    always_comb begin
        accept = vld && (sop || state == ACC);
        smp = '{pwr: pwr, idx: idx, vld: 1'b1};
        up_ge = {ge[TOPK-2:0], 1'b1};
        for (int i = 0; i < TOPK; i++) view[i] = sop ? EMPTY_SLOT : list[i];
        up[0] = EMPTY_SLOT;
        for (int i = 1; i < TOPK; i++) up[i] = view[i-1];
        state_nxt = (vld && sop) ? (eop ? IDLE : ACC) : (vld && eop) ? IDLE : state;
    end

    for (genvar g = 0; g < TOPK; g++) begin : g_cell
        beam_rank_cell u_cell (
            .own      (view[g]),
            .upper    (up[g]),
            .smp      (smp),
            .upper_ge (up_ge[g]),
            .nxt      (nxt[g]),
            .ge       (ge[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld <= 1'b0;
            sop <= 1'b0;
            eop <= 1'b0;
            load <= 1'b0;
            pwr <= '0;
            idx <= '0;
            cnt <= '0;
            snap <= 1'b0;
            snap_load <= 1'b0;
            for (int i = 0; i < TOPK; i++) list[i] <= EMPTY_SLOT;
            o_sort_pwr <= '0;
            o_sort_idx <= '0;
            o_sort_cnt <= '0;
            o_sort_sop <= 1'b0;
            o_rbg_load <= 1'b0;
            o_err_sop <= 1'b0;
        end else begin
            vld <= i_pwr_vld;
            sop <= i_pwr_sop;
            eop <= i_pwr_eop;
            load <= i_rbg_load;
            pwr <= PWR_W'(i_pwr);
            idx <= IDX_W'(i_pwr_idx);
            o_err_sop <= vld && sop && state == ACC;
            snap <= accept && eop;
            snap_load <= load;
            o_sort_sop <= snap;
            o_rbg_load <= snap && snap_load;
            if (accept) begin
                list <= nxt;
                cnt <= sop ? CNT_WIDTH'(1) : (&cnt) ? cnt : cnt + 1'b1;
            end
            // list and cnt here are pre-update values, so a back-to-back sop cannot corrupt the snapshot
            if (snap) begin
                for (int i = 0; i < TOPK; i++) begin
                    o_sort_pwr[i] <= list[i].vld ? PWR_WIDTH'(list[i].pwr) : '0;
                    o_sort_idx[i] <= list[i].vld ? IDX_WIDTH'(list[i].idx) : IDX_WIDTH'(EMPTY_IDX);
                end
                o_sort_cnt <= (cnt >= CNT_WIDTH'(TOPK)) ? 5'(TOPK) : 5'(cnt);
            end
        end
    end
endmodule

// File: tb/tb_beam_pwr_rank.sv
// tb_beam_pwr_rank: directed scoreboard bench for the top-16 beam ranker
module tb_beam_pwr_rank;
    logic clk = 1'b0;
    logic rst;
    logic pwr_vld, pwr_sop, pwr_eop, rbg_load;
    logic [31:0] pwr;
    logic [7:0] pwr_idx;
    logic [15:0][31:0] sort_pwr;
    logic [15:0][7:0] sort_idx;
    logic [4:0] sort_cnt;
    logic sort_sop, out_load, err_sop;

    typedef struct {
        logic [15:0][31:0] pwr;
        logic [15:0][7:0] idx;
        logic [4:0] cnt;
        logic load;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, n_snap = 0, n_push = 0, err_seen = 0, err_exp = 0;
    bit open = 0;
    int n = 0;
    logic [31:0] bp[256];
    logic [7:0] bi[256];

    beam_pwr_rank dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_pwr_vld  (pwr_vld),
        .i_pwr_sop  (pwr_sop),
        .i_pwr_eop  (pwr_eop),
        .i_pwr      (pwr),
        .i_pwr_idx  (pwr_idx),
        .i_rbg_load (rbg_load),
        .o_sort_pwr (sort_pwr),
        .o_sort_idx (sort_idx),
        .o_sort_cnt (sort_cnt),
        .o_sort_sop (sort_sop),
        .o_rbg_load (out_load),
        .o_err_sop  (err_sop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // reference: stable descending selection over all beats of the RBG
    task automatic push_expected(input logic ld);
        exp_t e;
        bit used[256];
        int best;
        for (int j = 0; j < 256; j++) used[j] = 0;
        for (int k = 0; k < 16; k++) begin
            best = -1;
            for (int j = 0; j < n && j < 256; j++)
                if (!used[j] && (best < 0 || bp[j] > bp[best])) best = j;
            if (best >= 0) begin
                used[best] = 1;
                e.pwr[k] = bp[best];
                e.idx[k] = bi[best];
            end else begin
                e.pwr[k] = '0;
                e.idx[k] = 8'hFF;
            end
        end
        e.cnt = (n > 16) ? 5'd16 : 5'(n);
        e.load = ld;
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [31:0] p,
                        input logic [7:0] x, input logic ld);
        pwr_vld = v; pwr_sop = s; pwr_eop = e; pwr = p; pwr_idx = x; rbg_load = ld;
        @(posedge clk); #1;
        if (v) begin
            if (s) begin
                if (open) err_exp++;
                open = 1;
                n = 0;
            end
            if (open) begin
                if (n < 256) begin bp[n] = p; bi[n] = x; end
                n++;
            end
            if (open && e) begin
                push_expected(ld);
                open = 0;
            end
        end
        pwr_vld = 0; pwr_sop = 0; pwr_eop = 0;
    endtask

    task automatic idle(input int c);
        pwr_vld = 0; pwr_sop = 0; pwr_eop = 0;
        repeat (c) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pwr"}, sort_pwr, 0);
        chk({tag, "_idx"}, sort_idx, 0);
        chk({tag, "_cnt"}, sort_cnt, 0);
        chk({tag, "_sop"}, sort_sop, 0);
        chk({tag, "_load"}, out_load, 0);
        chk({tag, "_err"}, err_sop, 0);
    endtask

    always @(negedge clk) begin
        if (sort_sop) begin
            n_snap++;
            chk("snap_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("snap_pwr", sort_pwr, e.pwr);
                chk("snap_idx", sort_idx, e.idx);
                chk("snap_cnt", sort_cnt, e.cnt);
                chk("snap_load", out_load, e.load);
                chk("snap_cycle", cyc, e.cyc);
            end
        end
        if (err_sop) err_seen++;
    end

    initial begin
        logic [31:0] t1 [8];
        t1 = '{5, 90, 12, 90, 3, 40, 7, 1};
        rst = 1;
        pwr_vld = 0; pwr_sop = 0; pwr_eop = 0; pwr = 0; pwr_idx = 0; rbg_load = 0;
        idle(3);
        rst = 0;
        idle(1);
        check_reset_outputs("reset");
        // stray beats in IDLE: dropped, eop without sop ignored
        beat(1, 0, 0, 32'd999, 8'd50, 0);
        beat(1, 0, 1, 32'd999, 8'd51, 1);
        idle(4);
        // single RBG of 8 beams with a vld gap inside
        for (int i = 0; i < 8; i++) begin
            beat(1, i == 0, i == 7, t1[i], 8'(i), 0);
            if (i == 3) idle(2);
        end
        idle(4);
        // 64 beams, pwr = idx*3, load flagged on eop
        for (int i = 0; i < 64; i++) beat(1, i == 0, i == 63, 32'(i * 3), 8'(i), i == 63);
        // back-to-back: short RBG then equal-power RBG with no gap
        for (int i = 0; i < 4; i++) beat(1, i == 0, i == 3, 32'(100 - i * 7), 8'(20 + i), 1);
        for (int i = 0; i < 20; i++) beat(1, i == 0, i == 19, 32'd7, 8'(i), 0);
        idle(4);
        // missing eop: first RBG discarded, second completes
        for (int i = 0; i < 3; i++) beat(1, i == 0, 0, 32'(500 + i), 8'(i), 0);
        for (int i = 0; i < 5; i++) beat(1, i == 0, i == 4, 32'(i * 11 + 3), 8'(30 + i), 1);
        idle(4);
        // single-beam RBG
        beat(1, 1, 1, 32'h1234, 8'd9, 0);
        idle(4);
        chk("err_count", err_seen, err_exp);
        chk("snap_count", n_snap, n_push);
        // reset mid-RBG, then a lone eop
        beat(1, 1, 0, 32'd77, 8'd1, 0);
        beat(1, 0, 0, 32'd66, 8'd2, 0);
        rst = 1;
        idle(1);
        rst = 0;
        open = 0;
        beat(1, 0, 1, 32'd55, 8'd3, 1);
        idle(6);
        check_reset_outputs("post_reset");
        chk("pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
